debounce_multi: RTL

Parametrised N-channel push-button/switch debouncer generalising the team's single-channel lockout debouncer. It adds per-channel state, a selectable immediate-lockout or stable-qualify mode, one-cycle edge pulses, an asynchronous active-low reset and an optional input synchroniser. It sits between raw board buttons/switches and the control logic that consumes clean levels and single-cycle press/release events.

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_chan.sv | 121 ++++++++++++
 rtl/debounce_multi.sv | 36 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and channel state encoding for the debounce_multi block.
package debounce_pkg;

    localparam int MODE_IMMEDIATE = 0;  // accept on first change, then lock out
    localparam int MODE_STABLE    = 1;  // accept only after the input has held

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        QUAL = 2'd2
    } chan_state_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: optional 2-flop synchroniser, counter, IDLE/LOCK/QUAL
// state machine, registered debounced level and one-cycle rise/fall pulses.
// Build option: define DEBOUNCE_SYNC_EN to insert the input synchroniser.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int LOCK_CYCLES = 1000000,
    parameter int MODE        = MODE_IMMEDIATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic out_reg,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOCK_CYCLES);
    localparam logic [CW-1:0] CNT_QUAL = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic            s;
    chan_state_t     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_d, rise_d, fall_d;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser so btn may be fully asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], btn};
    end

    assign s = sync_q[1];
`else
    assign s = btn;
`endif

    // State, counter, debounced level and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_reg <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_reg <= out_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // Next-state logic; pulses default low so they last exactly one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_reg;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s != out_reg) begin
                    if (MODE == MODE_IMMEDIATE) begin
                        out_d   = s;
                        rise_d  = s;
                        fall_d  = ~s;
                        cnt_d   = CNT_LOAD;
                        state_d = LOCK;
                    end else if (LOCK_CYCLES == 1) begin
                        // A single stable sample is already enough.
                        out_d  = s;
                        rise_d = s;
                        fall_d = ~s;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = QUAL;
                    end
                end
            end
            LOCK: begin
                // Leave on the decrement that reaches zero so the next change
                // can be taken one cycle later (spacing LOCK_CYCLES+1).
                if (cnt_q == CNT_ONE || cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            QUAL: begin
                if (s == out_reg) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_QUAL) begin
                    out_d   = s;
                    rise_d  = s;
                    fall_d  = ~s;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/debounce_multi.sv
// N-channel button/switch debouncer: CHANNELS independent debounce_chan
// instances sharing clock, reset, LOCK_CYCLES and MODE.
// Build option: define DEBOUNCE_SYNC_EN to add a 2-flop input synchroniser
// per channel (2 cycles extra latency).
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int LOCK_CYCLES = 1000000,
    parameter int MODE        = MODE_IMMEDIATE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] out_reg,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .LOCK_CYCLES (LOCK_CYCLES),
            .MODE        (MODE)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn     (btn[i]),
            .out_reg (out_reg[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .busy    (busy[i])
        );
    end

endmodule
